tick_monitor: RTL

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_monitor_pkg.sv | 28 ++
 rtl/tick_interval_cnt.sv | 65 ++++++
 rtl/tick_monitor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tick_monitor_pkg.sv
// Shared types, parameter defaults and helpers for the tick monitor.
package tick_monitor_pkg;

    localparam int unsigned PERIOD_DEF = 20001;
    localparam int unsigned TOL_DEF    = 2;
    localparam int unsigned LOCK_N_DEF = 4;
    localparam int unsigned CBITS_DEF  = 16;
    localparam int unsigned FAULT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_FAULT  = 2'd3
    } state_e;

    typedef struct packed {
        logic early;
        logic late;
        logic miss;
        logic valid;
    } pulse_t;

    function automatic logic [FAULT_W-1:0] sat_inc(input logic [FAULT_W-1:0] v);
        return (v == {FAULT_W{1'b1}}) ? v : v + FAULT_W'(1);
    endfunction

endpackage

// File: rtl/tick_interval_cnt.sv
// Saturating interval counter with early/late/overdue classification of its value.
module tick_interval_cnt
    import tick_monitor_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned TOL    = TOL_DEF,
    parameter int unsigned CBITS  = CBITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    output logic [CBITS-1:0] icnt_o,
    output logic             early_c_o,
    output logic             late_c_o,
    output logic             overdue_c_o
);

    // One extra bit so limits beyond the counter range never alias.
    localparam int unsigned      CW      = CBITS + 1;
    localparam logic [CW-1:0]    LO_LIM  = CW'(PERIOD - TOL);
    localparam logic [CW-1:0]    HI_LIM  = CW'(PERIOD + TOL);
    localparam logic [CW-1:0]    MISS_AT = CW'(PERIOD + TOL + 1);
    localparam logic [CBITS-1:0] CNT_MAX = {CBITS{1'b1}};

    logic [CBITS-1:0] icnt_q, icnt_d;
    logic             overdue_seen_q, overdue_seen_d;
    logic [CW-1:0]    icnt_ext;
    logic             at_miss;

    assign icnt_ext = CW'(icnt_q);
    assign at_miss  = (icnt_ext == MISS_AT);

    // Reload on tick, otherwise count up and hold at full scale.
    always_comb begin
        icnt_d         = icnt_q;
        overdue_seen_d = overdue_seen_q;
        if (tick_i) begin
            icnt_d         = CBITS'(1);
            overdue_seen_d = 1'b0;
        end else begin
            if (icnt_q != CNT_MAX) begin
                icnt_d = icnt_q + CBITS'(1);
            end
            if (at_miss) begin
                overdue_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q         <= '0;
            overdue_seen_q <= 1'b0;
        end else begin
            icnt_q         <= icnt_d;
            overdue_seen_q <= overdue_seen_d;
        end
    end

    assign icnt_o      = icnt_q;
    assign early_c_o   = (icnt_ext < LO_LIM);
    assign late_c_o    = (icnt_ext > HI_LIM);
    assign overdue_c_o = at_miss && !overdue_seen_q;

endmodule

// File: rtl/tick_monitor.sv
// Lock/fault monitor for a periodic tick: measures intervals, classifies them
// and tracks lock acquisition and loss.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int unsigned PERIOD = PERIOD_DEF,
    parameter int unsigned TOL    = TOL_DEF,
    parameter int unsigned LOCK_N = LOCK_N_DEF,
    parameter int unsigned CBITS  = CBITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    output logic               locked,
    output logic               early,
    output logic               late,
    output logic               miss,
    output logic               valid,
    output logic [CBITS-1:0]   period_q,
    output logic [FAULT_W-1:0] fault_cnt
);

    localparam int unsigned   GW        = $clog2(LOCK_N + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_N - 1);

    state_e               state_q, state_d;
    logic [GW-1:0]        good_cnt_q, good_cnt_d;
    logic [FAULT_W-1:0]   fault_cnt_q, fault_cnt_d;
    logic [CBITS-1:0]     period_reg_q, period_reg_d;
    logic                 locked_q, locked_d;
    pulse_t               pulse_q, pulse_d;

    logic [CBITS-1:0]     icnt;
    logic                 early_c, late_c, overdue_c;
    logic                 tracking_c, classify_c, good_c, miss_c;

    tick_interval_cnt #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .CBITS  (CBITS)
    ) u_icnt (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick),
        .icnt_o      (icnt),
        .early_c_o   (early_c),
        .late_c_o    (late_c),
        .overdue_c_o (overdue_c)
    );

    // Ticks are only judged while acquiring or locked; a coincident tick beats a miss.
    assign tracking_c = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
    assign classify_c = tick && tracking_c;
    assign good_c     = !early_c && !late_c;
    assign miss_c     = !tick && tracking_c && overdue_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_ACQ;
            end
            ST_ACQ: begin
                if (classify_c && good_c && (good_cnt_q == LOCK_LAST)) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if ((classify_c && !good_c) || miss_c) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (tick) state_d = ST_ACQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pulse_d      = '0;
        period_reg_d = period_reg_q;
        good_cnt_d   = good_cnt_q;
        fault_cnt_d  = fault_cnt_q;
        locked_d     = (state_d == ST_LOCKED);

        if (classify_c) begin
            pulse_d.valid = 1'b1;
            pulse_d.early = early_c;
            pulse_d.late  = late_c;
            period_reg_d  = icnt;
        end
        pulse_d.miss = miss_c;

        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (tick) good_cnt_d = '0;
            end
            ST_ACQ: begin
                if (classify_c && good_c) begin
                    good_cnt_d = good_cnt_q + GW'(1);
                end else if (classify_c || miss_c) begin
                    good_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (state_d == ST_FAULT) fault_cnt_d = sat_inc(fault_cnt_q);
            end
            default: good_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_q   <= '0;
            fault_cnt_q  <= '0;
            period_reg_q <= '0;
            locked_q     <= 1'b0;
            pulse_q      <= '0;
        end else begin
            good_cnt_q   <= good_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
            period_reg_q <= period_reg_d;
            locked_q     <= locked_d;
            pulse_q      <= pulse_d;
        end
    end

    assign locked    = locked_q;
    assign early     = pulse_q.early;
    assign late      = pulse_q.late;
    assign miss      = pulse_q.miss;
    assign valid     = pulse_q.valid;
    assign period_q  = period_reg_q;
    assign fault_cnt = fault_cnt_q;

endmodule
